// File: rtl/time_pkg.sv
// Shared types and constants for the MM:SS time editor.
package time_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Digit k holds num1[4k+3:4k]: min tens, min units, sec tens, sec units.
    localparam logic [3:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};
    localparam logic [3:0] CURSOR_RST = 4'b0001;

    function automatic logic [15:0] clamp_time(input logic [15:0] t);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = (t[4*k +: 4] > DIGIT_MAX[k]) ? 4'd0 : t[4*k +: 4];
        end
        return r;
    endfunction

    // Wrap one cursor-selected digit up or down; no carry or borrow.
    function automatic logic [15:0] bump(
        input logic [15:0] num,
        input logic [3:0]  cur,
        input logic        up
    );
        logic [15:0] r;
        logic [3:0]  d;
        r = num;
        for (int k = 0; k < 4; k++) begin
            d = num[4*k +: 4];
            if (cur[k]) begin
                if (up) begin
                    r[4*k +: 4] = (d >= DIGIT_MAX[k]) ? 4'd0 : d + 4'd1;
                end else begin
                    r[4*k +: 4] = (d == 4'd0) ? DIGIT_MAX[k] : d - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_editor_if.sv
// Buttons, mode switch and edited-time outputs of the time editor.
interface time_editor_if;
    logic        enable;
    logic [15:0] current_time;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_confirm;
    logic [15:0] num1;
    logic [3:0]  which_seg_on1;
    logic        finish1;

    modport master (
        output enable, current_time,
        output btn_up, btn_down, btn_left, btn_right, btn_confirm,
        input  num1, which_seg_on1, finish1
    );

    modport slave (
        input  enable, current_time,
        input  btn_up, btn_down, btn_left, btn_right, btn_confirm,
        output num1, which_seg_on1, finish1
    );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop sync, stable-count debounce, rise pulse.
module btn_debounce #(
    parameter int unsigned      CNT_W           = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - 1'b1;

    logic             s1;
    logic             s2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            prev <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/time_editor.sv
// Set-time editor: debounced buttons drive a per-digit BCD edit
// of MM:SS with a blinking cursor and a one-cycle commit pulse.
module time_editor
    import time_pkg::*;
#(
    parameter int unsigned      CNT_W           = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input logic          clk,
    input logic          reset,
    time_editor_if.slave tif
);

    // Bit order sets event priority: confirm, up, down, left, right.
    logic [4:0] raw;
    logic [4:0] rise;
    logic [4:0] unused_level;

    assign raw = {tif.btn_confirm, tif.btn_up, tif.btn_down,
                  tif.btn_left, tif.btn_right};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .level(unused_level[i]),
            .rise (rise[i])
        );
    end

    state_t      state;
    state_t      state_n;
    logic [15:0] num_q;
    logic [15:0] num_n;
    logic [3:0]  seg_q;
    logic [3:0]  seg_n;
    logic        fin_q;
    logic        fin_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            num_q <= '0;
            seg_q <= '0;
            fin_q <= 1'b0;
        end else begin
            state <= state_n;
            num_q <= num_n;
            seg_q <= seg_n;
            fin_q <= fin_n;
        end
    end

    always_comb begin
        state_n = state;
        num_n   = num_q;
        seg_n   = seg_q;
        fin_n   = 1'b0;
        unique case (state)
            IDLE: begin
                seg_n = '0;
                if (tif.enable) begin
                    state_n = EDIT;
                    num_n   = clamp_time(tif.current_time);
                    seg_n   = CURSOR_RST;
                end
            end
            EDIT: begin
                if (!tif.enable) begin
                    state_n = IDLE;
                    seg_n   = '0;
                end else begin
                    priority case (1'b1)
                        rise[4]: begin
                            state_n = COMMIT;
                            fin_n   = 1'b1;
                        end
                        rise[3]: num_n = bump(num_q, seg_q, 1'b1);
                        rise[2]: num_n = bump(num_q, seg_q, 1'b0);
                        rise[1]: seg_n = {seg_q[2:0], seg_q[3]};
                        rise[0]: seg_n = {seg_q[0], seg_q[3:1]};
                        default: ;
                    endcase
                end
            end
            COMMIT: begin
                state_n = tif.enable ? EDIT : IDLE;
                if (!tif.enable) seg_n = '0;
            end
            default: begin
                state_n = IDLE;
                seg_n   = '0;
            end
        endcase
    end

    assign tif.num1          = num_q;
    assign tif.which_seg_on1 = seg_q;
    assign tif.finish1       = fin_q;

endmodule

// File: tb/tb_time_editor.sv
// Scoreboard bench for time_editor with a digit/cursor reference model.
module tb_time_editor;

    localparam int D = 4;

    typedef struct {
        string       tag;
        logic [15:0] num;
        logic [3:0]  seg;
        logic        fin;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    int dig[4];
    int cur;
    int mx[4] = '{9, 5, 9, 5};

    time_editor_if tif ();

    time_editor #(
        .CNT_W          (20),
        .DEBOUNCE_CYCLES(20'(D))
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .tif  (tif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mnum();
        return {4'(dig[3]), 4'(dig[2]), 4'(dig[1]), 4'(dig[0])};
    endfunction

    function automatic logic [3:0] mseg();
        return 4'(1 << cur);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] seg,
                            input logic fin, input int at);
        exp_t e;
        e.tag = tag;
        e.num = mnum();
        e.seg = seg;
        e.fin = fin;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic enter(input logic [15:0] t);
        int c;
        int v;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            v = int'(t[4*k +: 4]);
            dig[k] = (v > mx[k]) ? 0 : v;
        end
        cur = 0;
        push_exp("enter", mseg(), 1'b0, c + 1);
        tif.current_time = t;
        tif.enable = 1'b1;
        tick(3);
    endtask

    task automatic abort_edit();
        int c;
        c = cyc;
        push_exp("abort", 4'b0000, 1'b0, c + 1);
        tif.enable = 1'b0;
        tick(3);
    endtask

    // mask: {confirm, up, down, left, right}; only the highest acts.
    task automatic press(input logic [4:0] m, input int hold);
        int c;
        c = cyc;
        if (m[4]) begin
            push_exp("confirm", mseg(), 1'b1, c + D + 3);
        end else begin
            if (m[3]) dig[cur] = (dig[cur] + 1) % (mx[cur] + 1);
            else if (m[2]) dig[cur] = (dig[cur] + mx[cur]) % (mx[cur] + 1);
            else if (m[1]) cur = (cur + 1) % 4;
            else if (m[0]) cur = (cur + 3) % 4;
            push_exp("button", mseg(), 1'b0, c + D + 3);
        end
        {tif.btn_confirm, tif.btn_up, tif.btn_down,
         tif.btn_left, tif.btn_right} = m;
        tick(hold);
        {tif.btn_confirm, tif.btn_up, tif.btn_down,
         tif.btn_left, tif.btn_right} = 5'b0;
        tick(10);
    endtask

    task automatic glitch_up();
        tif.btn_up = 1'b1;
        tick(2);
        tif.btn_up = 1'b0;
        tick(10);
    endtask

    task automatic check_reset(input string tag);
        checks++;
        if (tif.num1 !== 16'h0 || tif.which_seg_on1 !== 4'b0
            || tif.finish1 !== 1'b0) begin
            errors++;
            $display("FAIL %s got num=%h seg=%b fin=%b required 0000 0000 0",
                     tag, tif.num1, tif.which_seg_on1, tif.finish1);
        end
    endtask

    // Monitor: any cursor/value change or finish pulse is one DUT output.
    initial begin
        logic [15:0] pn;
        logic [3:0]  ps;
        exp_t        e;
        pn = '0;
        ps = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (tif.num1 !== pn || tif.which_seg_on1 !== ps
                          || tif.finish1 !== 1'b0)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got num=%h seg=%b fin=%b required no change",
                             cyc, tif.num1, tif.which_seg_on1, tif.finish1);
                end else begin
                    e = q.pop_front();
                    if (tif.num1 !== e.num || tif.which_seg_on1 !== e.seg
                        || tif.finish1 !== e.fin || cyc != e.at) begin
                        errors++;
                        $display("FAIL %s got num=%h seg=%b fin=%b cyc=%0d required num=%h seg=%b fin=%b cyc=%0d",
                                 e.tag, tif.num1, tif.which_seg_on1, tif.finish1,
                                 cyc, e.num, e.seg, e.fin, e.at);
                    end
                end
            end
            pn = tif.num1;
            ps = tif.which_seg_on1;
        end
    end

    initial begin
        int r;
        logic [4:0] m;
        tif.enable = 1'b0;
        tif.current_time = '0;
        {tif.btn_confirm, tif.btn_up, tif.btn_down,
         tif.btn_left, tif.btn_right} = 5'b0;
        for (int k = 0; k < 4; k++) dig[k] = 0;
        cur = 0;
        tick(3);
        check_reset("power_on_reset");
        rst_n = 1'b1;
        tick(2);

        enter(16'h1234);
        abort_edit();
        enter(16'h7A59);
        abort_edit();
        enter(16'h5239);
        press(5'b01000, 10);
        press(5'b00100, 7);
        press(5'b00010, 8);
        press(5'b00010, 8);
        press(5'b00010, 8);
        press(5'b01000, 8);
        press(5'b00010, 8);
        press(5'b01010, 8);
        press(5'b10000, 8);
        glitch_up();
        abort_edit();
        enter(16'h0000);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 4) press(5'b01000, $urandom_range(6, 12));
            else if (r <= 8) press(5'b00100, $urandom_range(6, 12));
            else if (r <= 11) press(5'b00010, $urandom_range(6, 12));
            else if (r <= 14) press(5'b00001, $urandom_range(6, 12));
            else if (r <= 16) press(5'b10000, $urandom_range(6, 12));
            else if (r == 17) begin
                m = 5'($urandom_range(1, 31));
                press(m, $urandom_range(6, 12));
            end else if (r == 18) begin
                abort_edit();
                enter(16'($urandom));
            end else glitch_up();
        end

        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);

        // Reset while a confirm press is being debounced: no commit survives.
        tif.btn_confirm = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset("mid_edit_reset");
        tick(2);
        tif.btn_confirm = 1'b0;
        tif.enable = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) dig[k] = 0;
        tick(15);

        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_timeout got no output required num=%h seg=%b fin=%b",
                     e.tag, e.num, e.seg, e.fin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
